// File: rtl/emergency_preempt_arbiter_if.sv
// Request/grant bundle between the siren detectors, the preemption arbiter and the light controller.
interface emergency_preempt_arbiter_if;
  logic [3:0] req_raw;
  logic       vsw;
  logic       fault;
  logic [3:0] Emergency_green;
  logic       preempt_active;
  logic       timeout;

  modport master (
    output req_raw, vsw, fault,
    input  Emergency_green, preempt_active, timeout
  );

  modport slave (
    input  req_raw, vsw, fault,
    output Emergency_green, preempt_active, timeout
  );
endinterface

// File: rtl/emergency_preempt_arbiter.sv
// Synchronises, debounces and round-robin arbitrates four siren requests into a one-hot
// emergency-green grant with minimum hold, maximum hold and a clearance gap.
module emergency_preempt_arbiter #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned MIN_HOLD     = 40,
  parameter int unsigned MAX_HOLD     = 200,
  parameter int unsigned CLEAR_CYC    = 8
) (
  input logic                         clk,
  input logic                         reset,
  emergency_preempt_arbiter_if.slave  bus
);

  localparam logic [7:0] DbLast  = 8'(DEBOUNCE_CYC - 1);
  localparam logic [7:0] MinLast = 8'(MIN_HOLD - 1);
  localparam logic [7:0] MaxLast = 8'(MAX_HOLD - 1);
  localparam logic [7:0] ClrLast = 8'(CLEAR_CYC - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StClear} state_e;

  state_e     state_q, state_d;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] req_db_q, req_db_d;
  logic [7:0] db_cnt_q [4];
  logic [7:0] db_cnt_d [4];
  logic [3:0] mask_q, mask_d, elig;
  logic [7:0] hold_q, hold_d, clr_q, clr_d;
  logic [1:0] lane_q, lane_d, last_q, last_d, pick;
  logic       pick_vld, timeout_exit;
  logic [3:0] eg_q, eg_d;
  logic       pa_q, pa_d, to_q, to_d;

  // Input path: 2-flop synchroniser, then a per-lane counter that flips the debounced level
  // after DEBOUNCE_CYC consecutive samples disagreeing with it.
  always_comb begin
    req_db_d = req_db_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = 8'd0;
      if (sync2_q[i] != req_db_q[i]) begin
        if (db_cnt_q[i] == DbLast) req_db_d[i] = sync2_q[i];
        else                       db_cnt_d[i] = db_cnt_q[i] + 8'd1;
      end
    end
  end

  assign elig = req_db_q & ~mask_q;

  // Scan last+4 down to last+1 so the lane closest after last wins.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (elig[last_q + 2'(k)]) begin
        pick     = last_q + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    last_d       = last_q;
    hold_d       = hold_q;
    clr_d        = clr_q;
    timeout_exit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.vsw && !bus.fault && pick_vld) begin
          state_d = StGrant;
          lane_d  = pick;
          hold_d  = 8'd0;
        end
      end
      StGrant: begin
        if (hold_q != 8'hff) hold_d = hold_q + 8'd1;
        if (!bus.vsw || bus.fault || (hold_q == MaxLast) ||
            (!req_db_q[lane_q] && (hold_q >= MinLast))) begin
          state_d      = StClear;
          last_d       = lane_q;
          clr_d        = 8'd0;
          timeout_exit = bus.vsw && !bus.fault && (hold_q == MaxLast);
        end
      end
      StClear: begin
        if (clr_q == ClrLast) state_d = StIdle;
        else                  clr_d   = clr_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // A timed-out lane stays masked until its debounced request drops.
  assign mask_d = (mask_q & req_db_q) | (timeout_exit ? (4'b0001 << lane_q) : 4'b0000);

  always_comb begin
    eg_d = 4'b0000;
    pa_d = 1'b0;
    to_d = timeout_exit;
    if (state_d == StGrant) begin
      eg_d = 4'b0001 << lane_d;
      pa_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      eg_q    <= 4'b0000;
      pa_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      eg_q    <= eg_d;
      pa_q    <= pa_d;
      to_q    <= to_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      req_db_q <= 4'b0000;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= 8'd0;
      mask_q   <= 4'b0000;
      hold_q   <= 8'd0;
      clr_q    <= 8'd0;
      lane_q   <= 2'd0;
      last_q   <= 2'd3;
    end else begin
      sync1_q  <= bus.req_raw;
      sync2_q  <= sync1_q;
      req_db_q <= req_db_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      mask_q   <= mask_d;
      hold_q   <= hold_d;
      clr_q    <= clr_d;
      lane_q   <= lane_d;
      last_q   <= last_d;
    end
  end

  assign bus.Emergency_green = eg_q;
  assign bus.preempt_active  = pa_q;
  assign bus.timeout         = to_q;

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Directed bench for emergency_preempt_arbiter: latency, hold/clear timing, round-robin,
// debounce rejection, timeout masking, vsw/fault withdrawal and asynchronous reset.
module tb_emergency_preempt_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic seen;

  emergency_preempt_arbiter_if bus ();

  emergency_preempt_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b0;
    bus.req_raw = 4'b0000;
    bus.vsw     = 1'b1;
    bus.fault   = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_eg", {4'b0, bus.Emergency_green}, 8'h00);
    chk("rst_pa", {7'b0, bus.preempt_active}, 8'h00);
    chk("rst_to", {7'b0, bus.timeout}, 8'h00);

    // North latency, min hold, clear gap (E0 = this edge)
    reset       = 1'b1;
    bus.req_raw = 4'b0010;
    cyc(6);
    chk("lat_e6", {4'b0, bus.Emergency_green}, 8'h00);
    cyc(1);
    chk("lat_e7", {4'b0, bus.Emergency_green}, 8'h02);
    chk("lat_pa", {7'b0, bus.preempt_active}, 8'h01);
    cyc(5);
    bus.req_raw = 4'b0000;
    cyc(34);
    chk("minhold_e46", {4'b0, bus.Emergency_green}, 8'h02);
    cyc(1);
    chk("minhold_e47", {4'b0, bus.Emergency_green}, 8'h00);
    chk("minhold_pa", {7'b0, bus.preempt_active}, 8'h00);
    cyc(17);

    // West grant, then asynchronous reset mid-grant
    bus.req_raw = 4'b0100;
    cyc(7);
    chk("west_grant", {4'b0, bus.Emergency_green}, 8'h04);
    cyc(3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_eg", {4'b0, bus.Emergency_green}, 8'h00);
    chk("async_rst_pa", {7'b0, bus.preempt_active}, 8'h00);
    bus.req_raw = 4'b1001;
    cyc(2);

    // East+south tie after reset: east first, then south after CLEAR
    reset = 1'b1;
    cyc(6);
    chk("tie_e6", {4'b0, bus.Emergency_green}, 8'h00);
    cyc(1);
    chk("tie_east", {4'b0, bus.Emergency_green}, 8'h01);
    bus.req_raw = 4'b1000;
    cyc(39);
    chk("east_e46", {4'b0, bus.Emergency_green}, 8'h01);
    cyc(1);
    chk("east_e47", {4'b0, bus.Emergency_green}, 8'h00);
    cyc(8);
    chk("clear_e55", {4'b0, bus.Emergency_green}, 8'h00);
    cyc(1);
    chk("south_e56", {4'b0, bus.Emergency_green}, 8'h08);

    // vsw withdrawal while south granted and east also requesting
    bus.req_raw = 4'b1001;
    cyc(14);
    bus.vsw = 1'b0;
    cyc(1);
    chk("vsw_drop_eg", {4'b0, bus.Emergency_green}, 8'h00);
    chk("vsw_drop_pa", {7'b0, bus.preempt_active}, 8'h00);
    cyc(20);
    chk("vsw_hold_eg", {4'b0, bus.Emergency_green}, 8'h00);
    bus.vsw = 1'b1;
    cyc(1);
    chk("rr_east", {4'b0, bus.Emergency_green}, 8'h01);

    // fault withdrawal, then round-robin moves on to south
    cyc(3);
    bus.fault = 1'b1;
    cyc(1);
    chk("fault_eg", {4'b0, bus.Emergency_green}, 8'h00);
    chk("fault_pa", {7'b0, bus.preempt_active}, 8'h00);
    cyc(14);
    chk("fault_hold_eg", {4'b0, bus.Emergency_green}, 8'h00);
    bus.fault = 1'b0;
    cyc(1);
    chk("rr_south", {4'b0, bus.Emergency_green}, 8'h08);
    bus.req_raw = 4'b0000;
    cyc(60);
    chk("idle_after_south", {4'b0, bus.Emergency_green}, 8'h00);

    // Glitch and toggling on east are rejected by the debouncer
    seen        = 1'b0;
    bus.req_raw = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      seen = seen | (|bus.Emergency_green);
    end
    bus.req_raw = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      if (i >= 10 && (i % 2 == 0)) bus.req_raw[0] = ~bus.req_raw[0];
      cyc(1);
      seen = seen | (|bus.Emergency_green);
    end
    chk("glitch_reject", {7'b0, seen}, 8'h00);
    bus.req_raw = 4'b0000;
    cyc(10);

    // West stuck high times out, east served, west masked until it drops and re-rises
    bus.req_raw = 4'b0100;
    cyc(7);
    chk("to_west_grant", {4'b0, bus.Emergency_green}, 8'h04);
    bus.req_raw = 4'b0101;
    cyc(199);
    chk("to_t206_eg", {4'b0, bus.Emergency_green}, 8'h04);
    chk("to_t206_to", {7'b0, bus.timeout}, 8'h00);
    cyc(1);
    chk("to_t207_eg", {4'b0, bus.Emergency_green}, 8'h00);
    chk("to_t207_to", {7'b0, bus.timeout}, 8'h01);
    cyc(1);
    chk("to_t208_to", {7'b0, bus.timeout}, 8'h00);
    cyc(8);
    chk("to_east_grant", {4'b0, bus.Emergency_green}, 8'h01);
    bus.req_raw = 4'b0100;
    cyc(64);
    chk("west_masked", {4'b0, bus.Emergency_green}, 8'h00);
    bus.req_raw = 4'b0000;
    cyc(10);
    bus.req_raw = 4'b0100;
    cyc(6);
    chk("west_rearm_e6", {4'b0, bus.Emergency_green}, 8'h00);
    cyc(1);
    chk("west_regrant", {4'b0, bus.Emergency_green}, 8'h04);

    // North grant withdrawn by vsw on the next edge, without a timeout pulse
    reset       = 1'b0;
    bus.req_raw = 4'b0000;
    cyc(1);
    reset       = 1'b1;
    bus.req_raw = 4'b0010;
    cyc(7);
    chk("north_grant", {4'b0, bus.Emergency_green}, 8'h02);
    cyc(3);
    bus.vsw = 1'b0;
    cyc(1);
    chk("north_vsw_eg", {4'b0, bus.Emergency_green}, 8'h00);
    chk("north_vsw_to", {7'b0, bus.timeout}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
